// File: rtl/nx_loader_pkg.sv
// Shared definitions for the init loader: target codes, FSM states, header layout.
package nx_loader_pkg;

    // Record target codes carried in header bits [31:30]
    typedef enum logic [1:0] {
        TGT_INST = 2'b00,
        TGT_DATA = 2'b01,
        TGT_REG  = 2'b10,
        TGT_END  = 2'b11
    } tgt_e;

    // Loader FSM states
    typedef enum logic [1:0] {
        ST_HDR  = 2'b00,
        ST_LOAD = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } state_e;

    // Header field positions
    localparam int unsigned HDR_TGT_MSB  = 31;
    localparam int unsigned HDR_TGT_LSB  = 30;
    localparam int unsigned HDR_CNT_MSB  = 29;
    localparam int unsigned HDR_CNT_LSB  = 16;
    localparam int unsigned HDR_BASE_MSB = 15;
    localparam int unsigned HDR_BASE_LSB = 0;

    // Field and arithmetic widths
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned CNT_W     = 14;
    localparam int unsigned BASE_W    = 16;
    localparam int unsigned SUM_W     = 17;
    localparam int unsigned REG_AW    = 5;
    localparam int unsigned REG_DEPTH = 32;

endpackage

// File: rtl/nx_init_loader.sv
// Decodes framed load records from a word stream into the core's init write ports,
// holding the core in reset until an END record is accepted.
module nx_init_loader
    import nx_loader_pkg::*;
#(
    parameter int unsigned INST_DEPTH = 256,
    parameter int unsigned DATA_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              inst_ram_wen,
    output logic [WORD_W-1:0] inst_ram_waddr,
    output logic [WORD_W-1:0] inst_ram_wdata,
    output logic              data_ram_wen_initial,
    output logic [WORD_W-1:0] data_ram_waddr_initial,
    output logic [WORD_W-1:0] data_ram_wdata_initial,
    output logic              regfile_wen_initial,
    output logic [REG_AW-1:0] regfile_waddr_initial,
    output logic [WORD_W-1:0] regfile_wdata_initial,
    output logic              core_rst_n,
    output logic              done,
    output logic              err
);

    state_e              state_q;
    tgt_e                tgt_q;
    logic [BASE_W-1:0]   ptr_q;
    logic [CNT_W-1:0]    remain_q;

    logic                inst_wen_q;
    logic [WORD_W-1:0]   inst_addr_q;
    logic [WORD_W-1:0]   inst_data_q;
    logic                data_wen_q;
    logic [WORD_W-1:0]   data_addr_q;
    logic [WORD_W-1:0]   data_data_q;
    logic                reg_wen_q;
    logic [REG_AW-1:0]   reg_addr_q;
    logic [WORD_W-1:0]   reg_data_q;
    logic                core_rst_n_q;
    logic                done_q;
    logic                err_q;

    tgt_e                hdr_tgt;
    logic [CNT_W-1:0]    hdr_cnt;
    logic [BASE_W-1:0]   hdr_base;
    logic [SUM_W-1:0]    hdr_sum;
    logic [SUM_W-1:0]    hdr_limit;
    logic                hdr_oob;
    logic                accept;
    logic [WORD_W-1:0]   ram_addr;

    // Ready only in the record-consuming states, and never while reset is applied
    assign in_ready = ~rst & ((state_q == ST_HDR) | (state_q == ST_LOAD));
    assign accept   = in_valid & in_ready;
    assign ram_addr = {14'b0, ptr_q, 2'b00};

    // Header field split and bounds check against the selected target's depth
    always_comb begin
        hdr_tgt  = tgt_e'(in_data[HDR_TGT_MSB:HDR_TGT_LSB]);
        hdr_cnt  = in_data[HDR_CNT_MSB:HDR_CNT_LSB];
        hdr_base = in_data[HDR_BASE_MSB:HDR_BASE_LSB];
        hdr_sum  = SUM_W'(hdr_base) + SUM_W'(hdr_cnt);
        case (hdr_tgt)
            TGT_INST: hdr_limit = SUM_W'(INST_DEPTH);
            TGT_DATA: hdr_limit = SUM_W'(DATA_DEPTH);
            default:  hdr_limit = SUM_W'(REG_DEPTH);
        endcase
        hdr_oob = (hdr_sum > hdr_limit);
    end

    // Record FSM with registered write ports and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HDR;
            tgt_q        <= TGT_INST;
            ptr_q        <= '0;
            remain_q     <= '0;
            inst_wen_q   <= 1'b0;
            inst_addr_q  <= '0;
            inst_data_q  <= '0;
            data_wen_q   <= 1'b0;
            data_addr_q  <= '0;
            data_data_q  <= '0;
            reg_wen_q    <= 1'b0;
            reg_addr_q   <= '0;
            reg_data_q   <= '0;
            core_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            inst_wen_q   <= 1'b0;
            data_wen_q   <= 1'b0;
            reg_wen_q    <= 1'b0;
            // Release lags DONE by a cycle so the final write lands first
            core_rst_n_q <= (state_q == ST_DONE);
            case (state_q)
                ST_HDR: begin
                    if (accept) begin
                        if (hdr_tgt == TGT_END) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else if (hdr_cnt != '0) begin
                            if (hdr_oob) begin
                                state_q <= ST_ERR;
                                err_q   <= 1'b1;
                            end else begin
                                tgt_q    <= hdr_tgt;
                                ptr_q    <= hdr_base;
                                remain_q <= hdr_cnt;
                                state_q  <= ST_LOAD;
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        case (tgt_q)
                            TGT_INST: begin
                                inst_wen_q  <= 1'b1;
                                inst_addr_q <= ram_addr;
                                inst_data_q <= in_data;
                            end
                            TGT_DATA: begin
                                data_wen_q  <= 1'b1;
                                data_addr_q <= ram_addr;
                                data_data_q <= in_data;
                            end
                            TGT_REG: begin
                                reg_wen_q  <= 1'b1;
                                reg_addr_q <= ptr_q[REG_AW-1:0];
                                reg_data_q <= in_data;
                            end
                            default: begin
                            end
                        endcase
                        ptr_q    <= ptr_q + BASE_W'(1);
                        remain_q <= remain_q - CNT_W'(1);
                        if (remain_q == CNT_W'(1)) begin
                            state_q <= ST_HDR;
                        end
                    end
                end
                ST_DONE: begin
                end
                ST_ERR: begin
                end
                default: state_q <= ST_HDR;
            endcase
        end
    end

    assign inst_ram_wen           = inst_wen_q;
    assign inst_ram_waddr         = inst_addr_q;
    assign inst_ram_wdata         = inst_data_q;
    assign data_ram_wen_initial   = data_wen_q;
    assign data_ram_waddr_initial = data_addr_q;
    assign data_ram_wdata_initial = data_data_q;
    assign regfile_wen_initial    = reg_wen_q;
    assign regfile_waddr_initial  = reg_addr_q;
    assign regfile_wdata_initial  = reg_data_q;
    assign core_rst_n             = core_rst_n_q;
    assign done                   = done_q;
    assign err                    = err_q;

endmodule

// File: tb/tb_nx_init_loader.sv
// Scoreboard bench for nx_init_loader: driver pushes expected writes, monitor pops and compares.
module tb_nx_init_loader;
    import nx_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        inst_ram_wen;
    logic [31:0] inst_ram_waddr;
    logic [31:0] inst_ram_wdata;
    logic        data_ram_wen_initial;
    logic [31:0] data_ram_waddr_initial;
    logic [31:0] data_ram_wdata_initial;
    logic        regfile_wen_initial;
    logic [4:0]  regfile_waddr_initial;
    logic [31:0] regfile_wdata_initial;
    logic        core_rst_n;
    logic        done;
    logic        err;

    nx_init_loader #(.INST_DEPTH(256), .DATA_DEPTH(1024)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .in_data                (in_data),
        .inst_ram_wen           (inst_ram_wen),
        .inst_ram_waddr         (inst_ram_waddr),
        .inst_ram_wdata         (inst_ram_wdata),
        .data_ram_wen_initial   (data_ram_wen_initial),
        .data_ram_waddr_initial (data_ram_waddr_initial),
        .data_ram_wdata_initial (data_ram_wdata_initial),
        .regfile_wen_initial    (regfile_wen_initial),
        .regfile_waddr_initial  (regfile_waddr_initial),
        .regfile_wdata_initial  (regfile_wdata_initial),
        .core_rst_n             (core_rst_n),
        .done                   (done),
        .err                    (err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  tgt;
        logic [31:0] addr;
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle, at most one wen; every write must match the head of the scoreboard
    logic [2:0]  mon_w;
    logic [1:0]  mon_tgt;
    logic [31:0] mon_addr;
    logic [31:0] mon_data;
    exp_t        mon_e;
    initial begin
        forever begin
            @(negedge clk);
            mon_w = {inst_ram_wen, data_ram_wen_initial, regfile_wen_initial};
            chk("wen_onehot", 32'($countones(mon_w) <= 1), 32'd1);
            if (mon_w != 3'b000) begin
                mon_tgt  = inst_ram_wen ? 2'd0 : (data_ram_wen_initial ? 2'd1 : 2'd2);
                mon_addr = inst_ram_wen ? inst_ram_waddr :
                           (data_ram_wen_initial ? data_ram_waddr_initial : {27'b0, regfile_waddr_initial});
                mon_data = inst_ram_wen ? inst_ram_wdata :
                           (data_ram_wen_initial ? data_ram_wdata_initial : regfile_wdata_initial);
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL spurious_write: got wen=%b addr 0x%08h, expected no write (t=%0t)",
                             mon_w, mon_addr, $time);
                end else begin
                    mon_e = sb.pop_front();
                    chk("write_target", 32'(mon_tgt), 32'(mon_e.tgt));
                    chk("write_addr", mon_addr, mon_e.addr);
                    chk("write_data", mon_data, mon_e.data);
                    chk("write_cycle", cyc, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] hdr(input logic [1:0] t, input int unsigned cnt, input int unsigned base);
        return {t, 14'(cnt), 16'(base)};
    endfunction

    // Expected write appears one cycle after the acceptance edge
    task automatic push_exp(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
        sb.push_back('{tgt: t, addr: a, data: d, cyc: cyc + 1});
    endtask

    // Present one word for exactly one cycle; called on a falling edge
    task automatic send(input logic [31:0] w);
        in_valid = 1'b1;
        in_data  = w;
        chk("in_ready_on_send", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic gap_maybe(input bit gaps);
        if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    // Full record with model-computed addresses
    task automatic load_record(input logic [1:0] t, input int unsigned base, input int unsigned cnt, input bit gaps);
        logic [31:0] d;
        logic [31:0] a;
        gap_maybe(gaps);
        send(hdr(t, cnt, base));
        for (int i = 0; i < int'(cnt); i++) begin
            gap_maybe(gaps);
            d = $urandom;
            a = (t == 2'd2) ? 32'((base + i) % 32) : 32'((base + i) * 4);
            push_exp(t, a, d);
            send(d);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("in_ready_during_rst", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_wen", {29'b0, inst_ram_wen, data_ram_wen_initial, regfile_wen_initial}, 32'd0);
        chk("rst_inst_addr", inst_ram_waddr, 32'd0);
        chk("rst_inst_data", inst_ram_wdata, 32'd0);
        chk("rst_data_addr", data_ram_waddr_initial, 32'd0);
        chk("rst_data_data", data_ram_wdata_initial, 32'd0);
        chk("rst_reg_addr", 32'(regfile_waddr_initial), 32'd0);
        chk("rst_reg_data", regfile_wdata_initial, 32'd0);
        chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [1:0]  t;
        int unsigned lim;
        int unsigned cnt;

        @(negedge clk);
        do_reset();

        // INST directed: count 3 base 4 -> byte addresses 0x10, 0x14, 0x18
        send(32'h0003_0004);
        push_exp(2'd0, 32'h10, 32'hAAAA_0001); send(32'hAAAA_0001);
        push_exp(2'd0, 32'h14, 32'hBBBB_0002); send(32'hBBBB_0002);
        push_exp(2'd0, 32'h18, 32'hCCCC_0003); send(32'hCCCC_0003);
        chk("core_held_in_load", 32'(core_rst_n), 32'd0);

        // REG count 2 base 30, then END
        send(hdr(TGT_REG, 2, 30));
        push_exp(2'd2, 32'd30, 32'h1234_5678); send(32'h1234_5678);
        push_exp(2'd2, 32'd31, 32'h9ABC_DEF0); send(32'h9ABC_DEF0);
        send(hdr(TGT_END, 0, 0));
        chk("end_done_t1", 32'(done), 32'd1);
        chk("end_ready_t1", 32'(in_ready), 32'd0);
        chk("end_core_rst_n_t1", 32'(core_rst_n), 32'd0);
        @(negedge clk);
        chk("end_core_rst_n_t2", 32'(core_rst_n), 32'd1);
        chk("end_done_t2", 32'(done), 32'd1);
        chk("end_ready_t2", 32'(in_ready), 32'd0);
        chk("end_err", 32'(err), 32'd0);
        do_reset();

        // Bounds: REG base 30 count 3 overflows the regfile
        send(hdr(TGT_REG, 3, 30));
        chk("oob_err_t1", 32'(err), 32'd1);
        chk("oob_ready_t1", 32'(in_ready), 32'd0);
        chk("oob_core_rst_n_t1", 32'(core_rst_n), 32'd0);
        chk("oob_done_t1", 32'(done), 32'd0);
        @(negedge clk);
        chk("oob_err_sticky", 32'(err), 32'd1);
        chk("oob_core_rst_n_t2", 32'(core_rst_n), 32'd0);
        do_reset();

        // Bounds edge: DATA base 1023 count 1 fits exactly
        send(hdr(TGT_DATA, 1, 1023));
        push_exp(2'd1, 32'hFFC, 32'h0BAD_F00D); send(32'h0BAD_F00D);
        chk("edge_no_err", 32'(err), 32'd0);

        // Zero-count header produces nothing, then a gapped DATA record
        send(hdr(TGT_DATA, 0, 5));
        load_record(2'd1, 8, 4, 1'b1);
        load_record(2'd0, 100, 4, 1'b1);

        // Reset after 2 of 5 payloads, then a fresh INST record
        send(hdr(TGT_INST, 5, 20));
        push_exp(2'd0, 32'h50, 32'h5555_0000); send(32'h5555_0000);
        push_exp(2'd0, 32'h54, 32'h5555_0001); send(32'h5555_0001);
        do_reset();
        send(hdr(TGT_INST, 2, 2));
        push_exp(2'd0, 32'h08, 32'h6666_0000); send(32'h6666_0000);
        push_exp(2'd0, 32'h0C, 32'h6666_0001); send(32'h6666_0001);

        // Random in-bounds records with random valid gaps
        for (int r = 0; r < 20; r++) begin
            t   = 2'($urandom_range(0, 2));
            lim = (t == 2'd0) ? 256 : ((t == 2'd1) ? 1024 : 32);
            cnt = $urandom_range(1, 4);
            load_record(t, $urandom_range(0, lim - cnt), cnt, 1'b1);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        chk("final_core_held", 32'(core_rst_n), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
